l1_cache_dir_ctrl: RTL and testbench

- Synthesisable, clocked successor to the behavioural split-L1 trace model.
- Parametrised set-associative L1 tag/state directory with a request FSM, true-LRU replacement and a selectable write policy (write-back/write-allocate or write-through/no-allocate).
- Sits between the core-side request port and the L2 request port; it also services L2 inclusivity evictions and full-cache clears.
- Holds tags, valid, dirty and LRU state only; the data array lives elsewhere.

---
 rtl/l1_cache_dir_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_l1_cache_dir_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_cache_dir_ctrl.sv
// rtl/l1_cache_dir_ctrl.sv - set-associative L1 tag/state directory with request FSM and true-LRU
//
// Purpose:
//   Holds tag, valid, dirty and LRU-age state for a set-associative L1 cache.
//   A single request FSM serves core reads/writes, L2 inclusivity evictions and
//   full-cache clears. It issues line fills and writebacks/write-throughs to L2.
//   The data array lives elsewhere.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    core request handshake (ready only in IDLE)
//   req_op, req_addr       0 read, 1 write, 2 evict-from-L2, 3 clear; byte address
//   resp_valid, resp_hit   one-cycle completion pulse; tag presence at lookup
//   l2_req_valid/ready     L2 request handshake; op/addr stable while valid
//   l2_req_op, l2_req_addr 0 fill read, 1 write; line-aligned address
//   l2_fill_done           fill data delivered (only honoured in FILL_WAIT)
//   hit_cnt .. write_cnt   saturating statistics counters

module l1_cache_dir_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 6,
  parameter int WAYS         = 4,
  parameter int WRITE_BACK   = 1,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic                  l2_req_valid,
  input  logic                  l2_req_ready,
  output logic                  l2_req_op,
  output logic [ADDR_WIDTH-1:0] l2_req_addr,
  input  logic                  l2_fill_done,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt,
  output logic [CNT_WIDTH-1:0]  read_cnt,
  output logic [CNT_WIDTH-1:0]  write_cnt
);

  localparam int SETS      = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int WAY_W     = $clog2(WAYS);
  localparam bit WB_MODE   = (WRITE_BACK != 0);

  localparam logic [1:0] OP_RD  = 2'd0;
  localparam logic [1:0] OP_WR  = 2'd1;
  localparam logic [1:0] OP_EV  = 2'd2;
  localparam logic [1:0] OP_CLR = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB_REQ, S_FILL_REQ, S_FILL_WAIT, S_WT_REQ, S_RESP, S_CLEAR
  } state_t;

  typedef logic [WAYS-1:0][WAY_W-1:0] ages_t;

  state_t r_state, w_next_state;

  logic [TAG_WIDTH-1:0] r_tag   [SETS][WAYS];
  logic [WAYS-1:0]      r_valid [SETS];
  logic [WAYS-1:0]      r_dirty [SETS];
  ages_t                r_age   [SETS];

  logic [1:0]             r_op;
  logic [TAG_WIDTH-1:0]   r_req_tag;
  logic [INDEX_WIDTH-1:0] r_req_idx;
  logic [WAY_W-1:0]       r_way;
  logic                   r_hit;
  logic [INDEX_WIDTH-1:0] r_clr_idx;
  logic                   r_l2_op;
  logic [ADDR_WIDTH-1:0]  r_l2_addr;
  logic [CNT_WIDTH-1:0]   r_hit_cnt, r_miss_cnt, r_read_cnt, r_write_cnt;

  logic                  w_hit;
  logic [WAY_W-1:0]      w_hit_way;
  logic                  w_has_inv;
  logic [WAY_W-1:0]      w_inv_way;
  logic [WAY_W-1:0]      w_lru_way;
  logic [WAY_W-1:0]      w_victim;
  logic                  w_victim_dirty;
  logic [ADDR_WIDTH-1:0] w_line_addr;
  logic [ADDR_WIDTH-1:0] w_victim_addr;
  logic                  w_wt_write;
  logic                  w_unused;

  // Offset bits never matter to the directory.
  assign w_unused = ^req_addr[OFFSET_WIDTH-1:0];

  function automatic ages_t f_rst_ages();
    ages_t res;
    for (int v = 0; v < WAYS; v++) res[v] = WAY_W'(v);
    return res;
  endfunction

  // Move 'way' to most-recent; only younger ways age, so ages stay a permutation.
  function automatic ages_t f_touch(input ages_t ages, input logic [WAY_W-1:0] way);
    ages_t res;
    for (int v = 0; v < WAYS; v++)
      res[v] = (ages[v] < ages[way]) ? ages[v] + WAY_W'(1) : ages[v];
    res[way] = '0;
    return res;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] f_sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  assign w_line_addr = {r_req_tag, r_req_idx, {OFFSET_WIDTH{1'b0}}};
  assign w_wt_write  = (r_op == OP_WR) && !WB_MODE;

  // Parallel tag compare and victim choice for the latched set.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    w_lru_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_hit && r_valid[r_req_idx][w] && (r_tag[r_req_idx][w] == r_req_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (r_age[r_req_idx][w] == WAY_W'(WAYS-1)) w_lru_way = WAY_W'(w);
    end
    // Descending scan leaves the lowest-index invalid way selected.
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!r_valid[r_req_idx][w]) begin
        w_has_inv = 1'b1;
        w_inv_way = WAY_W'(w);
      end
    end
  end

  assign w_victim       = w_has_inv ? w_inv_way : w_lru_way;
  assign w_victim_dirty = r_valid[r_req_idx][w_victim] & r_dirty[r_req_idx][w_victim];
  assign w_victim_addr  = {r_tag[r_req_idx][w_victim], r_req_idx, {OFFSET_WIDTH{1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    l2_req_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next_state = S_LOOKUP;
      end
      S_LOOKUP: begin
        case (r_op)
          OP_CLR: w_next_state = S_CLEAR;
          OP_EV: begin
            if (w_hit && r_dirty[r_req_idx][w_hit_way]) w_next_state = S_WB_REQ;
            else                                        w_next_state = S_RESP;
          end
          default: begin
            if (w_hit)               w_next_state = w_wt_write ? S_WT_REQ : S_RESP;
            else if (w_wt_write)     w_next_state = S_WT_REQ;
            else if (w_victim_dirty) w_next_state = S_WB_REQ;
            else                     w_next_state = S_FILL_REQ;
          end
        endcase
      end
      S_WB_REQ: begin
        l2_req_valid = 1'b1;
        if (l2_req_ready) w_next_state = (r_op == OP_EV) ? S_RESP : S_FILL_REQ;
      end
      S_FILL_REQ: begin
        l2_req_valid = 1'b1;
        if (l2_req_ready) w_next_state = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (l2_fill_done) w_next_state = S_RESP;
      end
      S_WT_REQ: begin
        l2_req_valid = 1'b1;
        if (l2_req_ready) w_next_state = S_RESP;
      end
      S_RESP: begin
        resp_valid   = 1'b1;
        w_next_state = S_IDLE;
      end
      S_CLEAR: begin
        if (r_clr_idx == INDEX_WIDTH'(SETS-1)) w_next_state = S_RESP;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_age[s]   <= f_rst_ages();
        for (int w = 0; w < WAYS; w++) r_tag[s][w] <= '0;
      end
      r_op        <= OP_RD;
      r_req_tag   <= '0;
      r_req_idx   <= '0;
      r_way       <= '0;
      r_hit       <= 1'b0;
      r_clr_idx   <= '0;
      r_l2_op     <= 1'b0;
      r_l2_addr   <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_read_cnt  <= '0;
      r_write_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op      <= req_op;
            r_req_tag <= req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
            r_req_idx <= req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
            if (req_op == OP_RD) r_read_cnt  <= f_sat_inc(r_read_cnt);
            if (req_op == OP_WR) r_write_cnt <= f_sat_inc(r_write_cnt);
          end
        end
        S_LOOKUP: begin
          r_hit <= w_hit;
          r_way <= w_hit ? w_hit_way : w_victim;
          case (r_op)
            OP_CLR: begin
              r_hit       <= 1'b0;
              r_clr_idx   <= '0;
              r_hit_cnt   <= '0;
              r_miss_cnt  <= '0;
              r_read_cnt  <= '0;
              r_write_cnt <= '0;
            end
            OP_EV: begin
              if (w_hit) begin
                if (r_dirty[r_req_idx][w_hit_way]) begin
                  r_l2_op   <= 1'b1;
                  r_l2_addr <= w_line_addr;
                end else begin
                  r_valid[r_req_idx][w_hit_way] <= 1'b0;
                end
              end
            end
            default: begin
              if (w_hit) begin
                r_hit_cnt        <= f_sat_inc(r_hit_cnt);
                r_age[r_req_idx] <= f_touch(r_age[r_req_idx], w_hit_way);
                if (r_op == OP_WR) begin
                  if (WB_MODE) begin
                    r_dirty[r_req_idx][w_hit_way] <= 1'b1;
                  end else begin
                    r_l2_op   <= 1'b1;
                    r_l2_addr <= w_line_addr;
                  end
                end
              end else begin
                r_miss_cnt <= f_sat_inc(r_miss_cnt);
                if (w_wt_write) begin
                  r_l2_op   <= 1'b1;
                  r_l2_addr <= w_line_addr;
                end else if (w_victim_dirty) begin
                  r_l2_op   <= 1'b1;
                  r_l2_addr <= w_victim_addr;
                end else begin
                  r_l2_op   <= 1'b0;
                  r_l2_addr <= w_line_addr;
                end
              end
            end
          endcase
        end
        S_WB_REQ: begin
          if (l2_req_ready) begin
            if (r_op == OP_EV) begin
              r_valid[r_req_idx][r_way] <= 1'b0;
              r_dirty[r_req_idx][r_way] <= 1'b0;
            end else begin
              r_l2_op   <= 1'b0;
              r_l2_addr <= w_line_addr;
            end
          end
        end
        S_FILL_WAIT: begin
          if (l2_fill_done) begin
            r_tag[r_req_idx][r_way]   <= r_req_tag;
            r_valid[r_req_idx][r_way] <= 1'b1;
            r_dirty[r_req_idx][r_way] <= (r_op == OP_WR) && WB_MODE;
            r_age[r_req_idx]          <= f_touch(r_age[r_req_idx], r_way);
          end
        end
        S_CLEAR: begin
          // Dirty lines are dropped without writeback.
          r_valid[r_clr_idx] <= '0;
          r_dirty[r_clr_idx] <= '0;
          r_age[r_clr_idx]   <= f_rst_ages();
          r_clr_idx          <= r_clr_idx + INDEX_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign resp_hit    = r_hit;
  assign l2_req_op   = r_l2_op;
  assign l2_req_addr = r_l2_addr;
  assign hit_cnt     = r_hit_cnt;
  assign miss_cnt    = r_miss_cnt;
  assign read_cnt    = r_read_cnt;
  assign write_cnt   = r_write_cnt;

endmodule

// File: tb/tb_l1_cache_dir_ctrl.sv
// tb/tb_l1_cache_dir_ctrl.sv - self-checking bench for l1_cache_dir_ctrl (write-back and write-through)

module tb_l1_cache_dir_ctrl;

  localparam int AW = 32;
  localparam logic [1:0] RD = 2'd0, WR = 2'd1, EV = 2'd2, CL = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req_valid;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic          l2_req_ready;
  logic          l2_fill_done;
  logic          dut_sel;

  logic          wb_req_valid, wb_req_ready, wb_resp_valid, wb_resp_hit, wb_l2_valid, wb_l2_op;
  logic [AW-1:0] wb_l2_addr;
  logic [31:0]   wb_hit_cnt, wb_miss_cnt, wb_rd_cnt, wb_wr_cnt;
  logic          wt_req_valid, wt_req_ready, wt_resp_valid, wt_resp_hit, wt_l2_valid, wt_l2_op;
  logic [AW-1:0] wt_l2_addr;
  logic [31:0]   wt_hit_cnt, wt_miss_cnt, wt_rd_cnt, wt_wr_cnt;

  assign wb_req_valid = req_valid & ~dut_sel;
  assign wt_req_valid = req_valid & dut_sel;

  l1_cache_dir_ctrl #(.WRITE_BACK(1)) u_wb (
    .clk(clk), .rst_n(rst_n), .req_valid(wb_req_valid), .req_ready(wb_req_ready),
    .req_op(req_op), .req_addr(req_addr), .resp_valid(wb_resp_valid), .resp_hit(wb_resp_hit),
    .l2_req_valid(wb_l2_valid), .l2_req_ready(l2_req_ready), .l2_req_op(wb_l2_op),
    .l2_req_addr(wb_l2_addr), .l2_fill_done(l2_fill_done), .hit_cnt(wb_hit_cnt),
    .miss_cnt(wb_miss_cnt), .read_cnt(wb_rd_cnt), .write_cnt(wb_wr_cnt)
  );

  l1_cache_dir_ctrl #(.WRITE_BACK(0)) u_wt (
    .clk(clk), .rst_n(rst_n), .req_valid(wt_req_valid), .req_ready(wt_req_ready),
    .req_op(req_op), .req_addr(req_addr), .resp_valid(wt_resp_valid), .resp_hit(wt_resp_hit),
    .l2_req_valid(wt_l2_valid), .l2_req_ready(l2_req_ready), .l2_req_op(wt_l2_op),
    .l2_req_addr(wt_l2_addr), .l2_fill_done(l2_fill_done), .hit_cnt(wt_hit_cnt),
    .miss_cnt(wt_miss_cnt), .read_cnt(wt_rd_cnt), .write_cnt(wt_wr_cnt)
  );

  logic          m_req_ready, m_resp_valid, m_resp_hit, m_l2_valid, m_l2_op;
  logic [AW-1:0] m_l2_addr;
  logic [31:0]   m_hit_cnt, m_miss_cnt, m_rd_cnt, m_wr_cnt;

  assign m_req_ready  = dut_sel ? wt_req_ready  : wb_req_ready;
  assign m_resp_valid = dut_sel ? wt_resp_valid : wb_resp_valid;
  assign m_resp_hit   = dut_sel ? wt_resp_hit   : wb_resp_hit;
  assign m_l2_valid   = dut_sel ? wt_l2_valid   : wb_l2_valid;
  assign m_l2_op      = dut_sel ? wt_l2_op      : wb_l2_op;
  assign m_l2_addr    = dut_sel ? wt_l2_addr    : wb_l2_addr;
  assign m_hit_cnt    = dut_sel ? wt_hit_cnt    : wb_hit_cnt;
  assign m_miss_cnt   = dut_sel ? wt_miss_cnt   : wb_miss_cnt;
  assign m_rd_cnt     = dut_sel ? wt_rd_cnt     : wb_rd_cnt;
  assign m_wr_cnt     = dut_sel ? wt_wr_cnt     : wb_wr_cnt;

  typedef struct {
    logic        sel;
    logic [1:0]  op;
    logic [31:0] addr;
    logic        exp_hit;
    int          exp_lat;
    int          exp_nl2;
    logic        exp_op0;
    logic [31:0] exp_a0;
    logic        exp_op1;
    logic [31:0] exp_a1;
    logic [31:0] exp_h, exp_m, exp_r, exp_w;
  } vec_t;

  vec_t        vecs[$];
  logic        l2_op_log[$];
  logic [31:0] l2_addr_log[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          stable_err = 0;

  function automatic void add(input logic sel, input logic [1:0] op, input logic [31:0] addr,
                              input logic hit, input int lat, input int nl2,
                              input logic o0, input logic [31:0] a0,
                              input logic o1, input logic [31:0] a1,
                              input int h, input int m, input int r, input int w);
    vec_t v;
    v.sel = sel; v.op = op; v.addr = addr; v.exp_hit = hit; v.exp_lat = lat; v.exp_nl2 = nl2;
    v.exp_op0 = o0; v.exp_a0 = a0; v.exp_op1 = o1; v.exp_a1 = a1;
    v.exp_h = h; v.exp_m = m; v.exp_r = r; v.exp_w = w;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one request and plays the L2 side: each request waits one cycle
  // before ready, and a fill handshake is followed by a one-cycle fill_done.
  task automatic run_req(input logic sel, input logic [1:0] op, input logic [31:0] addr,
                         output logic hit, output int lat);
    int   k;
    logic pend, rdy_prev, prev_op, done;
    int   wcnt;
    l2_op_log.delete();
    l2_addr_log.delete();
    hit = 1'b0; lat = -1;
    dut_sel = sel;
    @(negedge clk);
    k = 0;
    while (!m_req_ready && k < 50) begin @(negedge clk); k++; end
    if (!m_req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL req_ready timeout: got 0 expected 1");
    end
    req_valid = 1'b1; req_op = op; req_addr = addr;
    @(negedge clk);
    req_valid = 1'b0;
    pend = 1'b0; rdy_prev = 1'b0; prev_op = 1'b0; wcnt = 0; done = 1'b0;
    for (k = 0; k < 200 && !done; k++) begin
      if (k > 0) @(negedge clk);
      l2_fill_done = 1'b0;
      if (rdy_prev) begin
        pend = 1'b0;
        if (prev_op == 1'b0) l2_fill_done = 1'b1;
      end
      l2_req_ready = 1'b0;
      if (m_l2_valid) begin
        if (!pend) begin
          pend = 1'b1; wcnt = 0; prev_op = m_l2_op;
          l2_op_log.push_back(m_l2_op);
          l2_addr_log.push_back(m_l2_addr);
        end else if (m_l2_op !== prev_op || m_l2_addr !== l2_addr_log[$]) begin
          stable_err++;
        end
        if (wcnt == 1) l2_req_ready = 1'b1;
        wcnt++;
      end
      rdy_prev = l2_req_ready;
      if (m_resp_valid) begin
        hit = m_resp_hit; lat = k + 1; done = 1'b1;
      end
    end
    l2_req_ready = 1'b0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL resp timeout: got no resp_valid expected one within 200 cycles");
    end
  endtask

  task automatic check_cnt(input string tag, input int h, input int m, input int r, input int w);
    check({tag, " hit_cnt"},   m_hit_cnt,  h);
    check({tag, " miss_cnt"},  m_miss_cnt, m);
    check({tag, " read_cnt"},  m_rd_cnt,   r);
    check({tag, " write_cnt"}, m_wr_cnt,   w);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2000000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hit;
    int   lat;
    int   k;

    // Write-back DUT (sel 0); index 1 lines are tag<<10 | 0x40.
    add(0, RD, 32'h1040, 0,  0, 1, 0, 32'h1040, 0, 0,        0, 1, 1, 0);
    add(0, RD, 32'h1040, 1,  2, 0, 0, 0,        0, 0,        1, 1, 2, 0);
    add(0, WR, 32'h1050, 1,  2, 0, 0, 0,        0, 0,        2, 1, 2, 1);
    add(0, CL, 32'h0000, 0, 18, 0, 0, 0,        0, 0,        0, 0, 0, 0);
    add(0, RD, 32'h1040, 0,  0, 1, 0, 32'h1040, 0, 0,        0, 1, 1, 0);
    add(0, CL, 32'h0000, 0, 18, 0, 0, 0,        0, 0,        0, 0, 0, 0);
    add(0, RD, 32'h0040, 0,  0, 1, 0, 32'h0040, 0, 0,        0, 1, 1, 0);
    add(0, RD, 32'h0440, 0,  0, 1, 0, 32'h0440, 0, 0,        0, 2, 2, 0);
    add(0, RD, 32'h0840, 0,  0, 1, 0, 32'h0840, 0, 0,        0, 3, 3, 0);
    add(0, RD, 32'h0c40, 0,  0, 1, 0, 32'h0c40, 0, 0,        0, 4, 4, 0);
    add(0, RD, 32'h0040, 1,  2, 0, 0, 0,        0, 0,        1, 4, 5, 0);
    add(0, RD, 32'h1040, 0,  0, 1, 0, 32'h1040, 0, 0,        1, 5, 6, 0);
    add(0, RD, 32'h0040, 1,  2, 0, 0, 0,        0, 0,        2, 5, 7, 0);
    add(0, RD, 32'h0440, 0,  0, 1, 0, 32'h0440, 0, 0,        2, 6, 8, 0);
    add(0, CL, 32'h0000, 0, 18, 0, 0, 0,        0, 0,        0, 0, 0, 0);
    add(0, WR, 32'h0040, 0,  0, 1, 0, 32'h0040, 0, 0,        0, 1, 0, 1);
    add(0, RD, 32'h0440, 0,  0, 1, 0, 32'h0440, 0, 0,        0, 2, 1, 1);
    add(0, RD, 32'h0840, 0,  0, 1, 0, 32'h0840, 0, 0,        0, 3, 2, 1);
    add(0, RD, 32'h0c40, 0,  0, 1, 0, 32'h0c40, 0, 0,        0, 4, 3, 1);
    add(0, RD, 32'h1040, 0,  0, 2, 1, 32'h0040, 0, 32'h1040, 0, 5, 4, 1);
    add(0, WR, 32'h0c40, 1,  2, 0, 0, 0,        0, 0,        1, 5, 4, 2);
    add(0, EV, 32'h0c40, 1,  0, 1, 1, 32'h0c40, 0, 0,        1, 5, 4, 2);
    add(0, RD, 32'h0c40, 0,  0, 1, 0, 32'h0c40, 0, 0,        1, 6, 5, 2);
    add(0, EV, 32'h2040, 0,  2, 0, 0, 0,        0, 0,        1, 6, 5, 2);
    add(0, EV, 32'h0440, 1,  2, 0, 0, 0,        0, 0,        1, 6, 5, 2);
    add(0, RD, 32'h0440, 0,  0, 1, 0, 32'h0440, 0, 0,        1, 7, 6, 2);
    // Write-through DUT (sel 1).
    add(1, WR, 32'h0080, 0,  0, 1, 1, 32'h0080, 0, 0,        0, 1, 0, 1);
    add(1, RD, 32'h0080, 0,  0, 1, 0, 32'h0080, 0, 0,        0, 2, 1, 1);
    add(1, WR, 32'h0090, 1,  0, 1, 1, 32'h0080, 0, 0,        1, 2, 1, 2);
    add(1, EV, 32'h0080, 1,  2, 0, 0, 0,        0, 0,        1, 2, 1, 2);
    add(1, RD, 32'h0080, 0,  0, 1, 0, 32'h0080, 0, 0,        1, 3, 2, 2);

    rst_n = 1'b0; req_valid = 1'b0; req_op = RD; req_addr = '0;
    l2_req_ready = 1'b0; l2_fill_done = 1'b0; dut_sel = 1'b0;
    repeat (3) @(negedge clk);

    check("rst req_ready",  m_req_ready, 1);
    check("rst resp_valid", m_resp_valid, 0);
    check("rst resp_hit",   m_resp_hit, 0);
    check("rst l2_valid",   m_l2_valid, 0);
    check("rst l2_op",      m_l2_op, 0);
    check("rst l2_addr",    m_l2_addr, 0);
    check_cnt("rst", 0, 0, 0, 0);
    dut_sel = 1'b1; #1;
    check("rst wt req_ready", m_req_ready, 1);
    check("rst wt l2_valid",  m_l2_valid, 0);
    dut_sel = 1'b0;
    rst_n = 1'b1;

    // Stray fill_done while idle must be ignored.
    @(negedge clk); l2_fill_done = 1'b1;
    @(negedge clk); l2_fill_done = 1'b0;
    check("stray fill resp_valid", m_resp_valid, 0);
    check("stray fill req_ready",  m_req_ready, 1);

    foreach (vecs[i]) begin
      run_req(vecs[i].sel, vecs[i].op, vecs[i].addr, hit, lat);
      check($sformatf("v%0d resp_hit", i), hit, vecs[i].exp_hit);
      if (vecs[i].exp_lat != 0) check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d l2 count", i), l2_op_log.size(), vecs[i].exp_nl2);
      if (vecs[i].exp_nl2 >= 1 && l2_op_log.size() >= 1) begin
        check($sformatf("v%0d l2 op0", i),   l2_op_log[0],   vecs[i].exp_op0);
        check($sformatf("v%0d l2 addr0", i), l2_addr_log[0], vecs[i].exp_a0);
      end
      if (vecs[i].exp_nl2 >= 2 && l2_op_log.size() >= 2) begin
        check($sformatf("v%0d l2 op1", i),   l2_op_log[1],   vecs[i].exp_op1);
        check($sformatf("v%0d l2 addr1", i), l2_addr_log[1], vecs[i].exp_a1);
      end
      check_cnt($sformatf("v%0d", i), vecs[i].exp_h, vecs[i].exp_m, vecs[i].exp_r, vecs[i].exp_w);
    end

    check("l2 hold stable", stable_err, 0);

    // Reset while waiting for fill data.
    dut_sel = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = RD; req_addr = 32'h3040;
    @(negedge clk);
    req_valid = 1'b0;
    check("busy req_ready", m_req_ready, 0);
    k = 0;
    while (!m_l2_valid && k < 20) begin @(negedge clk); k++; end
    check("mid l2_valid", m_l2_valid, 1);
    check("mid l2_addr",  m_l2_addr, 32'h3040);
    l2_req_ready = 1'b1;
    @(negedge clk);
    l2_req_ready = 1'b0;
    @(negedge clk);
    check("mid read_cnt", m_rd_cnt, 7);
    rst_n = 1'b0;
    #1;
    check("arst l2_valid",  m_l2_valid, 0);
    check("arst l2_addr",   m_l2_addr, 0);
    check("arst req_ready", m_req_ready, 1);
    check_cnt("arst", 0, 0, 0, 0);
    @(negedge clk);
    check("arst hold req_ready",  m_req_ready, 1);
    check("arst hold resp_valid", m_resp_valid, 0);
    rst_n = 1'b1;

    run_req(0, RD, 32'h3040, hit, lat);
    check("post-rst hit", hit, 0);
    check("post-rst l2 count", l2_op_log.size(), 1);
    if (l2_op_log.size() >= 1) check("post-rst l2 addr", l2_addr_log[0], 32'h3040);
    check_cnt("post-rst", 0, 1, 1, 0);
    run_req(0, RD, 32'h0040, hit, lat);
    check("post-rst old line miss", hit, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
